// File: rtl/input_debouncer.sv
// Synchronizes and debounces push buttons and slide switches, producing stable
// levels plus one-cycle event pulses; a power-up settle phase sets the baseline.
module input_debouncer #(
    parameter int unsigned NUM_BUTTONS     = 4,
    parameter int unsigned NUM_SWITCHES    = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_WIDTH       = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BUTTONS-1:0]  btn_raw_n,
    input  logic [NUM_SWITCHES-1:0] sw_raw,
    output logic [NUM_BUTTONS-1:0]  btn_level,
    output logic [NUM_SWITCHES-1:0] sw_level,
    output logic [NUM_BUTTONS-1:0]  irq_buttons,
    output logic [NUM_SWITCHES-1:0] irq_switches,
    output logic                    ready
);

    localparam int unsigned NCH = NUM_BUTTONS + NUM_SWITCHES;
    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES + 1);

    logic [NUM_BUTTONS-1:0]  btn_meta_q, btn_sync_q;
    logic [NUM_SWITCHES-1:0] sw_meta_q, sw_sync_q;
    logic [NCH-1:0]          chan_sync_c;

    logic [0:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] settle_q, settle_d;
    logic [NCH-1:0]       level_q, level_d;
    logic [NCH-1:0]       pulse_q, pulse_d;
    logic                 ready_q, ready_d;
    logic [CNT_WIDTH-1:0] cnt_q [NCH];
    logic [CNT_WIDTH-1:0] cnt_d [NCH];

    // Two-flop synchronizers; buttons rest released (pin high)
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q <= '1;
            btn_sync_q <= '1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= btn_raw_n;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= sw_raw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Channel vector in internal sense: 1 = pressed / up
    assign chan_sync_c = {sw_sync_q, ~btn_sync_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            level_q  <= '0;
            pulse_q  <= '0;
            ready_q  <= 1'b0;
            cnt_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        level_d  = level_q;
        pulse_d  = '0;
        ready_d  = ready_q;
        cnt_d    = cnt_q;
        if (state_q == ST_SETTLE) begin
            level_d  = chan_sync_c;
            cnt_d    = '{default: '0};
            settle_d = settle_q + CNT_WIDTH'(1);
            if (settle_q == SETTLE_LAST) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (chan_sync_c[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = chan_sync_c[i];
                    cnt_d[i]   = '0;
                    // Buttons flag presses only; switches flag both directions
                    pulse_d[i] = (i >= int'(NUM_BUTTONS)) || chan_sync_c[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign btn_level    = level_q[NUM_BUTTONS-1:0];
    assign sw_level     = level_q[NCH-1:NUM_BUTTONS];
    assign irq_buttons  = pulse_q[NUM_BUTTONS-1:0];
    assign irq_switches = pulse_q[NCH-1:NUM_BUTTONS];
    assign ready        = ready_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with a window-based reference model checked
// every cycle, plus literal checkpoints along the test sequence.
module tb_input_debouncer;

    localparam int NB  = 4;
    localparam int NS  = 10;
    localparam int NCH = NB + NS;
    localparam int DC  = 8;
    localparam int HMAX = 4096;

    logic          clk;
    logic          reset;
    logic [NB-1:0] btn_raw_n;
    logic [NS-1:0] sw_raw;
    logic [NB-1:0] btn_level;
    logic [NS-1:0] sw_level;
    logic [NB-1:0] irq_buttons;
    logic [NS-1:0] irq_switches;
    logic          ready;

    int checks = 0;
    int errors = 0;

    input_debouncer #(
        .NUM_BUTTONS(NB), .NUM_SWITCHES(NS), .DEBOUNCE_CYCLES(DC), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw_n(btn_raw_n), .sw_raw(sw_raw),
        .btn_level(btn_level), .sw_level(sw_level), .irq_buttons(irq_buttons),
        .irq_switches(irq_switches), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw history indexed by edge number, internal sense
    logic [NCH-1:0] hist [HMAX];
    int             n        = 0;
    int             last_rst = 0;
    bit             model_valid = 0;
    logic [NCH-1:0] exp_level = '0;
    logic [NCH-1:0] exp_pulse = '0;
    logic           exp_ready = 1'b0;

    // Value at the synchronizer output just before edge m
    function automatic logic [NCH-1:0] sync_before(input int m);
        if (m - 2 > last_rst) return hist[m-2];
        return '0;
    endfunction

    always @(posedge clk) begin
        logic [NCH-1:0] sb;
        int j;
        n = n + 1;
        if (n < HMAX) hist[n] = {sw_raw, ~btn_raw_n};
        exp_pulse = '0;
        if (reset) begin
            last_rst    = n;
            model_valid = 1;
            exp_level   = '0;
            exp_ready   = 1'b0;
        end else begin
            j  = n - last_rst;
            sb = sync_before(n);
            if (j <= DC + 2) begin
                exp_level = sb;
                exp_ready = (j == DC + 2);
            end else begin
                exp_ready = 1'b1;
                for (int c = 0; c < NCH; c++) begin
                    if (sb[c] != exp_level[c] && (n - DC + 1 - last_rst > DC + 2)) begin
                        bit all_same;
                        all_same = 1;
                        for (int k = 0; k < DC; k++) begin
                            logic [NCH-1:0] w;
                            w = sync_before(n - k);
                            if (w[c] != sb[c]) all_same = 0;
                        end
                        if (all_same) begin
                            exp_level[c] = sb[c];
                            exp_pulse[c] = (c >= NB) ? 1'b1 : sb[c];
                        end
                    end
                end
            end
        end
    end

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            check("mdl_btn_level", 32'(btn_level), 32'(exp_level[NB-1:0]));
            check("mdl_sw_level", 32'(sw_level), 32'(exp_level[NCH-1:NB]));
            check("mdl_irq_buttons", 32'(irq_buttons), 32'(exp_pulse[NB-1:0]));
            check("mdl_irq_switches", 32'(irq_switches), 32'(exp_pulse[NCH-1:NB]));
            check("mdl_ready", 32'(ready), 32'(exp_ready));
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        sw_raw    = 10'h005;
        btn_raw_n = 4'hF;
        step(3);
        reset = 1'b0;

        // Settle phase: ready on the 10th edge, switches absorbed as baseline
        step(9);
        check("settle_ready_early", 32'(ready), 32'd0);
        step(1);
        check("settle_ready", 32'(ready), 32'd1);
        check("settle_sw_level", 32'(sw_level), 32'h005);
        check("settle_irq_sw", 32'(irq_switches), 32'h0);

        // Clean press on button 0, then release
        btn_raw_n = 4'b1110;
        step(9);
        check("press0_early", 32'(btn_level), 32'h0);
        step(1);
        check("press0_level", 32'(btn_level), 32'h1);
        check("press0_irq", 32'(irq_buttons), 32'h1);
        step(1);
        check("press0_irq_one_cycle", 32'(irq_buttons), 32'h0);
        btn_raw_n = 4'b1111;
        step(10);
        check("release0_level", 32'(btn_level), 32'h0);
        check("release0_irq", 32'(irq_buttons), 32'h0);

        // Glitch of DC-1 cycles is rejected
        btn_raw_n = 4'b1101;
        step(7);
        btn_raw_n = 4'b1111;
        step(15);
        check("glitch7_level", 32'(btn_level), 32'h0);

        // DC cycles is accepted
        btn_raw_n = 4'b1101;
        step(8);
        btn_raw_n = 4'b1111;
        step(2);
        check("hold8_level", 32'(btn_level), 32'h2);
        check("hold8_irq", 32'(irq_buttons), 32'h2);
        step(10);
        check("hold8_release", 32'(btn_level), 32'h0);

        // Switch 9 up then down, both directions pulse
        sw_raw = 10'h205;
        step(10);
        check("sw9_up_level", 32'(sw_level), 32'h205);
        check("sw9_up_irq", 32'(irq_switches), 32'h200);
        step(10);
        sw_raw = 10'h005;
        step(10);
        check("sw9_dn_level", 32'(sw_level), 32'h005);
        check("sw9_dn_irq", 32'(irq_switches), 32'h200);
        step(1);
        check("sw9_dn_irq_one_cycle", 32'(irq_switches), 32'h0);

        // Simultaneous acceptance on a button and a switch
        btn_raw_n = 4'b1011;
        sw_raw    = 10'h00D;
        step(10);
        check("simul_irq_btn", 32'(irq_buttons), 32'h4);
        check("simul_irq_sw", 32'(irq_switches), 32'h008);
        btn_raw_n = 4'b1111;
        step(12);

        // Reset while switch 3 release is mid-debounce
        sw_raw = 10'h005;
        step(7);
        reset = 1'b1;
        step(1);
        check("midrst_irq_sw", 32'(irq_switches), 32'h0);
        check("midrst_irq_btn", 32'(irq_buttons), 32'h0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_sw_level", 32'(sw_level), 32'h0);
        reset = 1'b0;
        step(9);
        check("resettle_ready_early", 32'(ready), 32'd0);
        step(1);
        check("resettle_ready", 32'(ready), 32'd1);
        check("resettle_sw_level", 32'(sw_level), 32'h005);
        step(20);
        check("resettle_quiet", 32'(irq_switches), 32'h0);
        check("resettle_sw_final", 32'(sw_level), 32'h005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream stage of interrupt_controller; conditions raw board inputs.
- Synchronizes and debounces the 4 push buttons (active-low at the pin) and the 10 slide switches.
- Exports stable levels for software readback.
- Produces one-cycle event pulses that drive interrupt_controller's irq_buttons and irq_switches inputs directly.
- Contains a power-up settle state machine so switches already set at reset raise no spurious interrupts.

Parameters:
- NUM_BUTTONS, 4, number of push-button channels.
- NUM_SWITCHES, 10, number of slide-switch channels.
- DEBOUNCE_CYCLES, 500000, consecutive clocks an input must hold a new value before acceptance (10 ms at 50 MHz); legal minimum 2.
- CNT_WIDTH, 19, width of each channel counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES + 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_raw_n  input  NUM_BUTTONS  raw button pins, 0 = pressed, asynchronous.
- sw_raw  input  NUM_SWITCHES  raw switch pins, 1 = up, asynchronous.
- btn_level  output  NUM_BUTTONS  debounced button state, 1 = pressed.
- sw_level  output  NUM_SWITCHES  debounced switch state.
- irq_buttons  output  NUM_BUTTONS  one-cycle pulse per bit on debounced press (0->1 of btn_level) only.
- irq_switches  output  NUM_SWITCHES  one-cycle pulse per bit on any debounced change of sw_level.
- ready  output  1  high once the settle phase has completed.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high. All registers update on the rising edge of clk.
- Synchronizer: 2-flop synchronizer per bit. Buttons are inverted after synchronization, so internal sense is 1 = pressed.
  - Reset values: button sync flops 1 (released); switch sync flops 0.
- Reset state:
  - btn_level = 0, sw_level = 0, irq_buttons = 0, irq_switches = 0, ready = 0.
  - All channel counters = 0; FSM = SETTLE; settle timer = 0.
- FSM states:
  - SETTLE: each cycle, btn_level and sw_level are loaded directly from the synchronized values. Channel counters held at 0. No pulses. Settle timer increments. When the timer equals DEBOUNCE_CYCLES+1, go to RUN and set ready = 1 on that same edge.
  - RUN: per-channel debounce as below. Stays in RUN until reset. No other transitions.
- Per-channel debounce in RUN:
  - If sync == level: counter <= 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: level <= sync, counter <= 0, pulse asserted for this edge only.
  - Else: counter <= counter + 1.
  - Net effect: a new value must be present at the synchronizer output for DEBOUNCE_CYCLES consecutive cycles.
- Latency: a clean raw transition held steady changes the level output and issues the pulse exactly 2 + DEBOUNCE_CYCLES cycles later.
- Glitch rejection: any reversion to the current level before acceptance clears the counter. A mismatch run of DEBOUNCE_CYCLES-1 or fewer cycles has no effect.
- Pulse registers:
  - Pulses are registered and are high for exactly one cycle per accepted change.
  - irq_buttons pulses on press only; release updates btn_level silently.
  - irq_switches pulses on both directions.
  - The next pulse on a channel is at least DEBOUNCE_CYCLES cycles after the previous one.
- Channel independence: channels are fully independent. Simultaneous acceptances on several channels raise all corresponding pulse bits in the same cycle.
- Counter bound: the counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset mid-operation:
  - Counters and pulses are cleared and the FSM returns to SETTLE.
  - Any in-progress debounce is discarded.
  - ready drops to 0 on the reset edge.
- Input value during SETTLE: whatever is present at the end of SETTLE becomes the baseline for RUN. Pulses occur only for changes relative to that baseline.

Test Plan (DEBOUNCE_CYCLES = 8 in bench):
- Hold reset 3 cycles with sw_raw = 10'h005 and btn_raw_n = 4'hF, then release. Required: ready = 1 on the 10th edge after reset deasserts; sw_level = 10'h005; no irq pulses at any point.
- After ready, drive btn_raw_n = 4'b1110 and hold. Required: btn_level = 4'b0001 and irq_buttons = 4'b0001 for exactly one cycle, 10 cycles later. Then drive 4'b1111. Required: btn_level returns to 0 after 10 cycles with no pulse.
- Drive btn_raw_n[1] low for 7 cycles, then high. Required: btn_level and irq_buttons unchanged throughout. Repeat with 8 cycles low. Required: one pulse on bit 1.
- Toggle sw_raw[9] 0->1, hold 20 cycles, then 1->0. Required: two separate one-cycle pulses on irq_switches[9]; sw_level[9] follows both transitions with 10-cycle latency.
- Drive btn_raw_n[2] low and sw_raw[3] high on the same edge. Required: irq_buttons = 4'b0100 and irq_switches = 10'h008 in the same cycle.
- Assert reset for 1 cycle at counter = 5 of a pending switch change. Required: all pulses 0, ready = 0, and a SETTLE phase follows. The switch value is absorbed as baseline with no pulse.
